mem_port_arbiter: RTL and testbench

- Shares the single memory port (cs/read_req/write_req/addrout/datatomem/datafrommem/mem_resp) between two requesters.
- Requester 0 is the instruction-unit load/store path; requester 1 is a second master (debug/preload loader).
- Round-robin arbitration, one outstanding transaction at a time, registered memory-side outputs.
- Sits between the requesters' store/load handshakes and the external memory.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;

    // Explicit encodings so external checkers can decode the debug state bus.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        RESP = ST_RESP
    } arb_state_t;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. Before the first completed transaction
// (last_valid_i = 0) requester 0 wins a tie; afterwards a tie goes to the
// requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] active_i,
    input  logic       last_grant_i,
    input  logic       last_valid_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    logic prefer;

    assign prefer        = last_valid_i & ~last_grant_i;
    assign grant_valid_o = |active_i;

    // Pick the preferred requester on a tie, otherwise the only active one.
    always_comb begin
        grant_o = 1'b0;
        if (active_i == 2'b11) begin
            grant_o = prefer;
        end else if (active_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two requesters, one transaction at a time,
// round-robin on contention, with registered memory-side outputs.
// Optional feature: define MEM_TIMEOUT_EN to complete a BUSY transaction with
// err after TIMEOUT cycles without mem_resp. Without it, BUSY waits forever and
// err is tied low.
//
// Handshake: a requester raises load or store (store wins if both) and holds
// it with a stable address until done pulses for one cycle; it must drop the
// request the cycle after done. The memory sees cs plus one strobe held until
// it answers with a one-cycle mem_resp; read data is sampled on that cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             load,
    input  logic [1:0]             store,
    input  logic [1:0][ADDR_W-1:0] addr,
    input  logic [1:0][DATA_W-1:0] wdata,
    output logic [1:0]             done,
    output logic [DATA_W-1:0]      rdata,
    output logic [1:0]             err,
    output logic                   cs,
    output logic                   read_req,
    output logic                   write_req,
    output logic [ADDR_W-1:0]      addrout,
    output logic [DATA_W-1:0]      datatomem,
    input  logic [DATA_W-1:0]      datafrommem,
    input  logic                   mem_resp,
    output arb_state_t             dbg_state_o
);

    arb_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              last_valid_q, last_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        done_q, done_d;

    logic [1:0]        active;
    logic              gnt;
    logic              gnt_valid;
    mem_op_t           new_op;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign active = load | store;
    assign new_op = store[gnt] ? MEM_WRITE : MEM_READ;

    rr_arbiter2 u_rr (
        .active_i      (active),
        .last_grant_i  (last_grant_q),
        .last_valid_i  (last_valid_q),
        .grant_o       (gnt),
        .grant_valid_o (gnt_valid)
    );

    // Next-state logic for the IDLE -> BUSY -> RESP transaction sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        last_valid_d = last_valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cs_d         = cs_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        done_d       = 2'b00;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 2'b00;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt;
                    op_d    = new_op;
                    addr_d  = addr[gnt];
                    wdata_d = wdata[gnt];
                    cs_d    = 1'b1;
                    rd_d    = (new_op == MEM_READ);
                    wr_d    = (new_op == MEM_WRITE);
                    state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    if (op_q == MEM_READ) begin
                        rdata_d = datafrommem;
                    end
                    cs_d             = 1'b0;
                    rd_d             = 1'b0;
                    wr_d             = 1'b0;
                    done_d[grant_q]  = 1'b1;
                    state_d          = RESP;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    cs_d             = 1'b0;
                    rd_d             = 1'b0;
                    wr_d             = 1'b0;
                    done_d[grant_q]  = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    state_d          = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                last_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= MEM_READ;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            last_valid_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cs_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            done_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            last_valid_q <= last_valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            done_q       <= done_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait counter and error flag for the BUSY timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
            err_q <= 2'b00;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 2'b00;
`endif

    assign done        = done_q;
    assign rdata       = rdata_q;
    assign cs          = cs_q;
    assign read_req    = rd_q;
    assign write_req   = wr_q;
    assign addrout     = addr_q;
    assign datatomem   = wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single load/store, store-over-load,
// round-robin ordering, ignored mem_resp, async reset abort and the BUSY
// timeout (or its absence when MEM_TIMEOUT_EN is undefined).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic             clk;
    logic             reset_n;
    logic [1:0]       load;
    logic [1:0]       store;
    logic [1:0][13:0] addr;
    logic [1:0][15:0] wdata;
    logic [1:0]       done;
    logic [15:0]      rdata;
    logic [1:0]       err;
    logic             cs;
    logic             read_req;
    logic             write_req;
    logic [13:0]      addrout;
    logic [15:0]      datatomem;
    logic [15:0]      datafrommem;
    logic             mem_resp;
    arb_state_t       dbg_state;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    mem_port_arbiter #(
        .ADDR_W  (14),
        .DATA_W  (16),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .store       (store),
        .addr        (addr),
        .wdata       (wdata),
        .done        (done),
        .rdata       (rdata),
        .err         (err),
        .cs          (cs),
        .read_req    (read_req),
        .write_req   (write_req),
        .addrout     (addrout),
        .datatomem   (datatomem),
        .datafrommem (datafrommem),
        .mem_resp    (mem_resp),
        .dbg_state_o (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // absolute time limit
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are checked 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        load        = 2'b00;
        store       = 2'b00;
        mem_resp    = 1'b0;
        datafrommem = 16'h0000;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // One uncontended transaction; mem_resp on the wait_cyc-th BUSY cycle.
    task automatic run_txn(input int who, input bit st, input bit ld,
                           input logic [13:0] a, input logic [15:0] wd,
                           input int wait_cyc, input logic [15:0] mdata,
                           input logic [15:0] exp_rdata);
        logic [1:0] m;
        m = 2'b01 << who;
        load[who]  = ld;
        store[who] = st;
        addr[who]  = a;
        wdata[who] = wd;
        tick();
        check("txn_cs", cs, 1);
        check("txn_rd", read_req, !st);
        check("txn_wr", write_req, st);
        check("txn_addr", addrout, a);
        if (st) check("txn_wdata", datatomem, wd);
        addr[who]  = ~a;
        wdata[who] = ~wd;
        for (int i = 1; i < wait_cyc; i++) begin
            tick();
            check("txn_hold_cs", cs, 1);
            check("txn_hold_rd", read_req, !st);
            check("txn_hold_addr", addrout, a);
        end
        mem_resp    = 1'b1;
        datafrommem = mdata;
        tick();
        mem_resp   = 1'b0;
        check("txn_done", done, m);
        check("txn_err", err, 0);
        check("txn_rdata", rdata, exp_rdata);
        check("txn_cs_drop", cs, 0);
        check("txn_strobes_drop", {read_req, write_req}, 0);
        load[who]  = 1'b0;
        store[who] = 1'b0;
        tick();
        check("txn_done_once", done, 0);
        check("txn_idle", dbg_state, IDLE);
    endtask

    // Serve the next granted transaction and compare against exp_q.
    task automatic serve(input logic [13:0] a0, input logic [13:0] a1);
        logic [1:0]  id;
        logic [1:0]  m;
        logic [13:0] ea;
        int          n;
        n = 0;
        while (!cs && n < 8) begin
            tick();
            n++;
        end
        check("serve_cs_seen", cs, 1);
        if (exp_q.size() == 0) begin
            check("serve_exp_q_empty", 1, 0);
            return;
        end
        id = exp_q.pop_front();
        ea = (id == 2'd0) ? a0 : a1;
        m  = 2'b01 << id;
        check("rr_addr", addrout, ea);
        mem_resp    = 1'b1;
        datafrommem = 16'h1000 + 16'(id);
        tick();
        mem_resp = 1'b0;
        check("rr_done", done, m);
        check("rr_rdata", rdata, 16'h1000 + 16'(id));
        load[id[0]] = 1'b0;
        tick();
    endtask

    initial begin
        addr  = '0;
        wdata = '0;
        do_reset();

        // reset state
        check("rst_state", dbg_state, IDLE);
        check("rst_cs", cs, 0);
        check("rst_strobes", {read_req, write_req}, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addrout", addrout, 0);
        check("rst_datatomem", datatomem, 0);
        check("rst_rdata", rdata, 0);

        // single load, response on the 2nd BUSY cycle
        run_txn(0, 1'b0, 1'b1, 14'h0123, 16'h0000, 2, 16'hBEEF, 16'hBEEF);
        // single store, rdata untouched
        run_txn(1, 1'b1, 1'b0, 14'h3FFF, 16'hA5A5, 1, 16'h1234, 16'hBEEF);
        // load and store together on requester 1: store wins
        run_txn(1, 1'b1, 1'b1, 14'h0042, 16'h5A5A, 3, 16'h7777, 16'hBEEF);

        // mem_resp in IDLE is ignored
        mem_resp    = 1'b1;
        datafrommem = 16'hFFFF;
        tick();
        mem_resp = 1'b0;
        check("idle_resp_state", dbg_state, IDLE);
        check("idle_resp_done", done, 0);
        check("idle_resp_rdata", rdata, 16'hBEEF);

        // round robin from reset
        do_reset();
        addr[0] = 14'h0010;
        addr[1] = 14'h0020;
        load    = 2'b11;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        serve(14'h0010, 14'h0020);
        serve(14'h0010, 14'h0020);
        // last grant was 1 -> requester 0 first again
        load = 2'b11;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        serve(14'h0010, 14'h0020);
        serve(14'h0010, 14'h0020);
        // requester 0 alone, then both -> requester 1 first
        load = 2'b01;
        exp_q.push_back(2'd0);
        serve(14'h0010, 14'h0020);
        load = 2'b11;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        serve(14'h0010, 14'h0020);
        serve(14'h0010, 14'h0020);
        check("rr_queue_drained", exp_q.size(), 0);

        // reset mid-BUSY aborts asynchronously
        addr[0] = 14'h0555;
        load    = 2'b01;
        tick();
        check("abort_busy_cs", cs, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_cs", cs, 0);
        check("abort_strobes", {read_req, write_req}, 0);
        check("abort_done", done, 0);
        load = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        check("abort_state", dbg_state, IDLE);
        check("abort_no_done", done, 0);

        // no mem_resp at all
        addr[0] = 14'h0077;
        load    = 2'b01;
        tick();
        check("to_cs_start", cs, 1);
`ifdef MEM_TIMEOUT_EN
        repeat (3) begin
            tick();
            check("to_cs_hold", cs, 1);
        end
        tick();
        check("to_cs_drop", cs, 0);
        check("to_done", done, 2'b01);
        check("to_err", err, 2'b01);
        check("to_rdata", rdata, 16'h0000);
        load = 2'b00;
        tick();
        check("to_done_once", done, 0);
        check("to_err_once", err, 0);
`else
        repeat (20) begin
            tick();
            if (done != 2'b00) check("nto_spurious_done", done, 0);
        end
        check("nto_cs_held", cs, 1);
        check("nto_state", dbg_state, BUSY);
        check("nto_err", err, 0);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
